// File: rtl/vga_pingpong_buf.sv
// vga_pingpong_buf: two-bank ping-pong line buffer between the fetch DMA and
// the VGA timing controller. The fetch side fills one bank with 32-bit words
// (two 12-bit pixels each) while the display side drains the other, one pixel
// per data_req_i, with data_o valid the cycle after the request.
//
// Optional build macro: VGA_PB_TESTPAT_EN adds testpat_i, which replaces bank
// reads with eight colour bars of DEPTH/8 pixels each.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   flush_i            synchronous clear of both banks and all pointers
//   wr_valid_i/_ready_o/wr_data_i  write word handshake; [11:0]=px n, [27:16]=px n+1
//   data_req_i         pop one pixel; data_o registered, valid next cycle
//   line_req_o         one-cycle pulse when a bank has been emptied
//   bank_full_o        per-bank full flag (full or draining)
//   underflow_o        sticky, set by a request that finds no full bank
//   underflow_clr_i    synchronous clear of underflow_o
//   testpat_i          (VGA_PB_TESTPAT_EN only) colour-bar test pattern enable
module vga_pingpong_buf #(
  parameter int unsigned DEPTH           = 640,
  parameter logic [11:0] UNDERFLOW_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic [31:0] wr_data_i,
  input  logic        data_req_i,
  output logic [11:0] data_o,
  output logic        line_req_o,
  output logic [1:0]  bank_full_o,
  output logic        underflow_o,
  input  logic        underflow_clr_i
`ifdef VGA_PB_TESTPAT_EN
  ,
  input  logic        testpat_i
`endif
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned HALF = DEPTH / 2;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

  bank_state_e   bank_q [2];
  bank_state_e   bank_d [2];
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          wr_ready_q, wr_ready_d;
  logic          line_req_q, line_req_d;
  logic          underflow_q, underflow_d;
  logic [1:0]    bank_full_q, bank_full_d;
  logic [11:0]   data_q;

  // Even and odd pixels live in separate halves so a word writes both in one cycle.
  logic [11:0]   mem_even [2][HALF];
  logic [11:0]   mem_odd  [2][HALF];

  logic          wr_acc_c, rd_hit_c, rd_uf_c, tp_req_c;
  logic [11:0]   bar_color_c;
  logic          unused_c;

  function automatic logic readable(input bank_state_e s);
    return (s == FULL) || (s == DRAINING);
  endfunction

  assign unused_c = ^{wr_data_i[31:28], wr_data_i[15:12]};

`ifdef VGA_PB_TESTPAT_EN
  localparam int unsigned BAR = DEPTH / 8;
  localparam int unsigned BW  = $clog2(BAR + 1);

  logic [BW-1:0] bar_px_q;
  logic [2:0]    bar_idx_q;

  assign tp_req_c    = testpat_i & data_req_i;
  // Bar index bits map directly onto the B, G and R nibbles.
  assign bar_color_c = {{4{bar_idx_q[2]}}, {4{bar_idx_q[1]}}, {4{bar_idx_q[0]}}};

  // Bar position counter; wraps after the eighth bar.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bar_px_q  <= '0;
      bar_idx_q <= '0;
    end else if (flush_i) begin
      bar_px_q  <= '0;
      bar_idx_q <= '0;
    end else if (tp_req_c) begin
      if (bar_px_q == BW'(BAR - 1)) begin
        bar_px_q  <= '0;
        bar_idx_q <= bar_idx_q + 3'd1;
      end else begin
        bar_px_q  <= bar_px_q + BW'(1);
      end
    end
  end
`else
  assign tp_req_c    = 1'b0;
  assign bar_color_c = 12'h000;
`endif

  // A write is only offered when the fill bank is writable, so ready alone qualifies it.
  assign wr_acc_c = wr_valid_i & wr_ready_q & ~flush_i;
  assign rd_hit_c = data_req_i & ~tp_req_c & ~flush_i &  readable(bank_q[rd_bank_q]);
  assign rd_uf_c  = data_req_i & ~tp_req_c & ~flush_i & ~readable(bank_q[rd_bank_q]);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bank_q[0]   <= EMPTY;
      bank_q[1]   <= EMPTY;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wr_ready_q  <= 1'b0;
      line_req_q  <= 1'b0;
      underflow_q <= 1'b0;
      bank_full_q <= 2'b00;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ready_q  <= wr_ready_d;
      line_req_q  <= line_req_d;
      underflow_q <= underflow_d;
      bank_full_q <= bank_full_d;
    end
  end

  // Next state: write and read sides never act on the same bank in one cycle.
  always_comb begin
    bank_d[0]   = bank_q[0];
    bank_d[1]   = bank_q[1];
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    line_req_d  = 1'b0;
    underflow_d = (underflow_q & ~underflow_clr_i) | rd_uf_c;

    if (wr_acc_c) begin
      if (wr_ptr_q == AW'(DEPTH - 2)) begin
        bank_d[wr_bank_q] = FULL;
        wr_ptr_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        bank_d[wr_bank_q] = FILLING;
        wr_ptr_d          = wr_ptr_q + AW'(2);
      end
    end

    if (rd_hit_c) begin
      if (rd_ptr_q == AW'(DEPTH - 1)) begin
        bank_d[rd_bank_q] = EMPTY;
        rd_ptr_d          = '0;
        rd_bank_d         = ~rd_bank_q;
        line_req_d        = 1'b1;
      end else begin
        bank_d[rd_bank_q] = DRAINING;
        rd_ptr_d          = rd_ptr_q + AW'(1);
      end
    end

    // Flush returns to the reset state and asks for a fresh line for bank 0.
    if (flush_i) begin
      bank_d[0]   = EMPTY;
      bank_d[1]   = EMPTY;
      wr_bank_d   = 1'b0;
      rd_bank_d   = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      line_req_d  = 1'b1;
      underflow_d = 1'b0;
    end

    // Ready follows the post-update state, so a freed bank opens one cycle after its last pop.
    wr_ready_d  = ~readable(bank_d[wr_bank_d]) & ~flush_i;
    bank_full_d = {readable(bank_d[1]), readable(bank_d[0])};
  end

  // Pixel storage write port.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem_even[wr_bank_q][wr_ptr_q[AW-1:1]] <= wr_data_i[11:0];
      mem_odd[wr_bank_q][wr_ptr_q[AW-1:1]]  <= wr_data_i[27:16];
    end
  end

  // Pixel output register; holds when there is no request or on flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q <= '0;
    end else if (tp_req_c && !flush_i) begin
      data_q <= bar_color_c;
    end else if (rd_hit_c) begin
      data_q <= rd_ptr_q[0] ? mem_odd[rd_bank_q][rd_ptr_q[AW-1:1]]
                            : mem_even[rd_bank_q][rd_ptr_q[AW-1:1]];
    end else if (rd_uf_c) begin
      data_q <= UNDERFLOW_COLOR;
    end
  end

  assign wr_ready_o  = wr_ready_q;
  assign data_o      = data_q;
  assign line_req_o  = line_req_q;
  assign bank_full_o = bank_full_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_vga_pingpong_buf.sv
// Self-checking bench for vga_pingpong_buf: a queue-based line model predicts
// every pixel and status flag; a monitor compares them against the DUT.
module tb_vga_pingpong_buf;

  localparam int unsigned DEPTH    = 640;
  localparam logic [11:0] UF_COLOR = 12'h000;

  logic        clk             = 1'b0;
  logic        resetn          = 1'b0;
  logic        flush_i         = 1'b0;
  logic        wr_valid_i      = 1'b0;
  logic        wr_ready_o;
  logic [31:0] wr_data_i       = '0;
  logic        data_req_i      = 1'b0;
  logic [11:0] data_o;
  logic        line_req_o;
  logic [1:0]  bank_full_o;
  logic        underflow_o;
  logic        underflow_clr_i = 1'b0;
`ifdef VGA_PB_TESTPAT_EN
  logic        testpat_i       = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_pingpong_buf #(.DEPTH(DEPTH), .UNDERFLOW_COLOR(UF_COLOR)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush_i         (flush_i),
    .wr_valid_i      (wr_valid_i),
    .wr_ready_o      (wr_ready_o),
    .wr_data_i       (wr_data_i),
    .data_req_i      (data_req_i),
    .data_o          (data_o),
    .line_req_o      (line_req_o),
    .bank_full_o     (bank_full_o),
    .underflow_o     (underflow_o),
    .underflow_clr_i (underflow_clr_i)
`ifdef VGA_PB_TESTPAT_EN
    ,
    .testpat_i       (testpat_i)
`endif
  );

  // Reference model: each bank is a queue of pixels; a bank is full once it holds a whole line.
  logic [11:0] mq [2][$];
  bit          m_full [2];
  bit          m_wb, m_rb;
  bit          m_ready, m_line, m_uf;
  int          tp_idx;
  logic [11:0] sb [$];
  logic [11:0] bars [8] = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF,
                            12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear(input bit line);
    mq[0].delete();
    mq[1].delete();
    m_full[0] = 0;
    m_full[1] = 0;
    m_wb      = 0;
    m_rb      = 0;
    m_ready   = 0;
    m_line    = line;
    m_uf      = 0;
    tp_idx    = 0;
  endtask

  task automatic model_step();
    bit new_uf = 0;
    bit tp     = 0;
`ifdef VGA_PB_TESTPAT_EN
    tp = testpat_i;
`endif
    m_line = 0;
    if (data_req_i && tp) begin
      sb.push_back(bars[tp_idx / (DEPTH / 8)]);
      tp_idx = (tp_idx + 1) % (8 * (DEPTH / 8));
    end else if (data_req_i) begin
      if (m_full[m_rb]) begin
        sb.push_back(mq[m_rb].pop_front());
        if (mq[m_rb].size() == 0) begin
          m_full[m_rb] = 0;
          m_rb         = !m_rb;
          m_line       = 1;
        end
      end else begin
        sb.push_back(UF_COLOR);
        new_uf = 1;
      end
    end
    if (wr_valid_i && m_ready) begin
      mq[m_wb].push_back(wr_data_i[11:0]);
      mq[m_wb].push_back(wr_data_i[27:16]);
      if (mq[m_wb].size() == DEPTH) begin
        m_full[m_wb] = 1;
        m_wb         = !m_wb;
      end
    end
    m_uf    = (m_uf && !underflow_clr_i) || new_uf;
    m_ready = !m_full[m_wb];
  endtask

  // Model advances on every active edge using the inputs the DUT sampled.
  initial begin
    model_clear(0);
    forever begin
      @(posedge clk);
      if (!resetn)      model_clear(0);
      else if (flush_i) model_clear(1);
      else              model_step();
    end
  end

  // Monitor: pops an expected pixel whenever a request produced one, and checks flags.
  initial begin
    logic [11:0] exp_px;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        sb.delete();
      end else begin
        if (sb.size() > 0) begin
          exp_px = sb.pop_front();
          check("data_o", 32'(data_o), 32'(exp_px));
        end
        check("wr_ready_o",  32'(wr_ready_o),  32'(m_ready));
        check("line_req_o",  32'(line_req_o),  32'(m_line));
        check("bank_full_o", 32'(bank_full_o), 32'({m_full[1], m_full[0]}));
        check("underflow_o", 32'(underflow_o), 32'(m_uf));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_word(input logic [31:0] d);
    int budget = 3000;
    bit done   = 0;
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    while (!done && budget > 0) begin
      done = wr_ready_o;
      step();
      budget--;
    end
    wr_valid_i = 1'b0;
    if (!done) check("write_timeout", 32'd0, 32'd1);
  endtask

  task automatic fill_index(input int n);
    for (int i = 0; i < n; i++)
      write_word({4'hA, 12'(2 * i + 1), 4'h5, 12'(2 * i)});
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) write_word($urandom);
  endtask

  task automatic pop(input int n);
    data_req_i = 1'b1;
    step(n);
    data_req_i = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    check("rst_data_o", 32'(data_o), 32'h0);
    check("rst_wr_ready", 32'(wr_ready_o), 32'h0);
    check("rst_bank_full", 32'(bank_full_o), 32'h0);
    check("rst_line_req", 32'(line_req_o), 32'h0);
    check("rst_underflow", 32'(underflow_o), 32'h0);
    resetn = 1'b1;
    step();

    // Fill bank 0 with pixel = index
    fill_index(DEPTH / 2);
    check("t1_bank_full", 32'(bank_full_o), 32'h1);
    check("t1_wr_ready", 32'(wr_ready_o), 32'h1);

    // Drain bank 0; line request afterwards
    pop(DEPTH);
    check("t2_line_req_pulse", 32'(line_req_o), 32'h1);
    check("t2_bank_full", 32'(bank_full_o), 32'h0);
    check("t2_last_px", 32'(data_o), 32'(DEPTH - 1));
    step();
    check("t2_line_req_single", 32'(line_req_o), 32'h0);

    // Both banks full: ready low until the read bank is emptied
    fill_random(DEPTH);
    wr_valid_i = 1'b1;
    wr_data_i  = $urandom;
    step(3);
    check("t3_ready_both_full", 32'(wr_ready_o), 32'h0);
    data_req_i = 1'b1;
    step(DEPTH - 1);
    check("t3_ready_before_free", 32'(wr_ready_o), 32'h0);
    step();
    check("t3_ready_after_free", 32'(wr_ready_o), 32'h1);
    data_req_i = 1'b0;
    wr_valid_i = 1'b0;
    pop(DEPTH);

    // Underflow: sticky, clear loses to a simultaneous new underflow
    pop(1);
    check("t4_uf_color", 32'(data_o), 32'(UF_COLOR));
    check("t4_uf_set", 32'(underflow_o), 32'h1);
    step(2);
    check("t4_uf_sticky", 32'(underflow_o), 32'h1);
    underflow_clr_i = 1'b1;
    pop(1);
    check("t4_uf_clr_vs_new", 32'(underflow_o), 32'h1);
    step();
    underflow_clr_i = 1'b0;
    check("t4_uf_cleared", 32'(underflow_o), 32'h0);

    // Randomised traffic
    for (int c = 0; c < 4000; c++) begin
      wr_valid_i      = ($urandom_range(0, 9) < 7);
      wr_data_i       = $urandom;
      data_req_i      = ($urandom_range(0, 9) < 4);
      underflow_clr_i = ($urandom_range(0, 19) == 0);
      flush_i         = ($urandom_range(0, 399) == 0);
      step();
    end
    wr_valid_i      = 1'b0;
    data_req_i      = 1'b0;
    underflow_clr_i = 1'b0;
    flush_i         = 1'b1;
    step();
    flush_i = 1'b0;
    step();

    // Mid-line flush with a write and a read in the same cycle
    fill_random(DEPTH / 2);
    fill_random(100);
    pop(100);
    flush_i    = 1'b1;
    data_req_i = 1'b1;
    wr_valid_i = 1'b1;
    step();
    flush_i    = 1'b0;
    data_req_i = 1'b0;
    wr_valid_i = 1'b0;
    check("t5_flush_bank_full", 32'(bank_full_o), 32'h0);
    check("t5_flush_line_req", 32'(line_req_o), 32'h1);
    step();
    check("t5_flush_line_single", 32'(line_req_o), 32'h0);
    fill_index(DEPTH / 2);
    check("t5_refill_bank0", 32'(bank_full_o), 32'h1);
    pop(2);
    check("t5_refill_px1", 32'(data_o), 32'h1);

    // Asynchronous reset in the middle of a write burst
    wr_valid_i = 1'b1;
    wr_data_i  = $urandom;
    step(5);
    #2 resetn = 1'b0;
    #1;
    check("t5_arst_data_o", 32'(data_o), 32'h0);
    check("t5_arst_bank_full", 32'(bank_full_o), 32'h0);
    check("t5_arst_wr_ready", 32'(wr_ready_o), 32'h0);
    check("t5_arst_line_req", 32'(line_req_o), 32'h0);
    wr_valid_i = 1'b0;
    step(2);
    resetn = 1'b1;
    step();
    check("t5_post_rst_ready", 32'(wr_ready_o), 32'h1);

`ifdef VGA_PB_TESTPAT_EN
    // Colour bars without touching the banks
    testpat_i = 1'b1;
    pop(DEPTH);
    testpat_i = 1'b0;
    check("t6_last_bar", 32'(data_o), 32'hFFF);
    check("t6_no_underflow", 32'(underflow_o), 32'h0);
`endif

    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
